// File: rtl/spi_flash_block_reader.sv
// SPI (mode 3) flash block reader: issues a read command plus address, optionally
// clocks dummy cycles, then streams BLOCK_SIZE received bytes out as BRAM write strobes.
module spi_flash_block_reader #(
    parameter int unsigned BLOCK_SIZE  = 512,
    parameter int unsigned SPI_CLK_DIV = 10,
    parameter int unsigned ADDR_BYTES  = 3,
    parameter int unsigned FAST_READ   = 0,
    localparam int unsigned IdxW       = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [8*ADDR_BYTES-1:0]   i_read_addr,
    input  logic                      i_read_stb,
    input  logic                      i_abort,
    output logic                      o_busy,
    output logic                      o_read_done_stb,
    output logic                      o_write_bram_stb,
    output logic [IdxW-1:0]           o_write_bram_addr,
    output logic [7:0]                o_write_bram_data,
    output logic                      o_spi_cs_n,
    output logic                      o_spi_clk,
    output logic                      o_spi_mosi,
    input  logic                      i_spi_miso
);

    localparam int unsigned TxW      = 8 + 8 * ADDR_BYTES;
    localparam int unsigned AddrBits = 8 * ADDR_BYTES;

    localparam logic [7:0] Cmd = (ADDR_BYTES == 4) ? ((FAST_READ != 0) ? 8'h0C : 8'h13)
                                                   : ((FAST_READ != 0) ? 8'h0B : 8'h03);

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StCsHold
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [TxW-1:0]     tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               wstb_q, wstb_d;
    logic               done_q, done_d;
    logic [IdxW-1:0]    waddr_q, waddr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               tick;

    assign tick = (state_q != StIdle) && (div_q == 8'(SPI_CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = tick ? 8'd0 : div_q + 8'd1;
        bit_d   = bit_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        wstb_d  = 1'b0;
        done_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            StIdle: begin
                div_d = 8'd0;
                if (i_read_stb) begin
                    state_d = StCsSetup;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    mosi_d  = 1'b1;
                    busy_d  = 1'b1;
                    tx_d    = {Cmd, i_read_addr};
                    bit_d   = 6'd0;
                    idx_d   = '0;
                    rx_d    = 8'd0;
                end
            end
            StCsSetup: begin
                // bit_q counts setup ticks; the second one launches the first command bit
                if (tick) begin
                    if (bit_q == 6'd0) begin
                        bit_d = 6'd1;
                    end else begin
                        sclk_d  = 1'b0;
                        mosi_d  = tx_q[TxW-1];
                        tx_d    = tx_q << 1;
                        bit_d   = 6'd0;
                        state_d = StCmd;
                    end
                end
            end
            StCmd, StAddr, StDummy, StData: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (state_q == StCmd || state_q == StAddr) begin
                            mosi_d = tx_q[TxW-1];
                            tx_d   = tx_q << 1;
                        end else begin
                            mosi_d = 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 6'd1;
                        case (state_q)
                            StCmd: begin
                                if (bit_q == 6'd7) begin
                                    bit_d   = 6'd0;
                                    state_d = StAddr;
                                end
                            end
                            StAddr: begin
                                if (bit_q == 6'(AddrBits - 1)) begin
                                    bit_d   = 6'd0;
                                    state_d = (FAST_READ != 0) ? StDummy : StData;
                                end
                            end
                            StDummy: begin
                                if (bit_q == 6'd7) begin
                                    bit_d   = 6'd0;
                                    state_d = StData;
                                end
                            end
                            StData: begin
                                rx_d = {rx_q[6:0], i_spi_miso};
                                if (bit_q == 6'd7) begin
                                    bit_d   = 6'd0;
                                    wstb_d  = 1'b1;
                                    waddr_d = idx_q;
                                    wdata_d = {rx_q[6:0], i_spi_miso};
                                    idx_d   = idx_q + 1'b1;
                                    if (idx_q == IdxW'(BLOCK_SIZE - 1)) begin
                                        state_d = StCsHold;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StCsHold: begin
                if (tick) begin
                    state_d = StIdle;
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b1;
                    mosi_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bit_d   = 6'd0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort only applies to an active transaction; a strobe in the same idle cycle wins.
        if (i_abort && state_q != StIdle) begin
            state_d = StIdle;
            div_d   = 8'd0;
            bit_d   = 6'd0;
            idx_d   = '0;
            rx_d    = 8'd0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
            mosi_d  = 1'b1;
            busy_d  = 1'b0;
            wstb_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            div_q   <= 8'd0;
            bit_q   <= 6'd0;
            idx_q   <= '0;
            tx_q    <= '0;
            rx_q    <= 8'd0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b1;
            busy_q  <= 1'b0;
            wstb_q  <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            wstb_q  <= wstb_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_busy            = busy_q;
    assign o_read_done_stb   = done_q;
    assign o_write_bram_stb  = wstb_q;
    assign o_write_bram_addr = waddr_q;
    assign o_write_bram_data = wdata_q;
    assign o_spi_cs_n        = cs_n_q;
    assign o_spi_clk         = sclk_q;
    assign o_spi_mosi        = mosi_q;

endmodule

// File: tb/tb_spi_flash_block_reader.sv
// Bench for spi_flash_block_reader: three configurations driven against a flash slave model
// that decodes the command/address from MOSI and serves bytes from a fixed memory function.
module tb_spi_flash_block_reader;

    typedef struct {
        logic        cs_prev;
        logic        sclk_prev;
        logic        miso;
        logic        seen_tog;
        logic [63:0] hdr;
        int          edges;
        int          strobes;
        int          str_bad;
        int          dones;
        int          both;
        int          mosi_bad;
        int          hp_min;
        int          hp_max;
        int          hp_cnt;
    } mon_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  stb, abort, cs_n, sclk, mosi, miso, busy, wstb, done;
    logic [31:0] addr_in [3];
    logic [31:0] req [3];
    logic [3:0]  ba0;
    logic [1:0]  ba1;
    logic [0:0]  ba2;
    logic [7:0]  bd0, bd1, bd2;
    mon_t        st [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    spi_flash_block_reader #(.BLOCK_SIZE(16), .SPI_CLK_DIV(3), .ADDR_BYTES(3), .FAST_READ(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_read_addr(addr_in[0][23:0]), .i_read_stb(stb[0]),
        .i_abort(abort[0]), .o_busy(busy[0]), .o_read_done_stb(done[0]),
        .o_write_bram_stb(wstb[0]), .o_write_bram_addr(ba0), .o_write_bram_data(bd0),
        .o_spi_cs_n(cs_n[0]), .o_spi_clk(sclk[0]), .o_spi_mosi(mosi[0]), .i_spi_miso(miso[0])
    );

    spi_flash_block_reader #(.BLOCK_SIZE(4), .SPI_CLK_DIV(1), .ADDR_BYTES(4), .FAST_READ(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_read_addr(addr_in[1]), .i_read_stb(stb[1]),
        .i_abort(abort[1]), .o_busy(busy[1]), .o_read_done_stb(done[1]),
        .o_write_bram_stb(wstb[1]), .o_write_bram_addr(ba1), .o_write_bram_data(bd1),
        .o_spi_cs_n(cs_n[1]), .o_spi_clk(sclk[1]), .o_spi_mosi(mosi[1]), .i_spi_miso(miso[1])
    );

    spi_flash_block_reader #(.BLOCK_SIZE(2), .SPI_CLK_DIV(255), .ADDR_BYTES(3), .FAST_READ(0)) u2 (
        .i_clk(clk), .i_rst(rst), .i_read_addr(addr_in[2][23:0]), .i_read_stb(stb[2]),
        .i_abort(abort[2]), .o_busy(busy[2]), .o_read_done_stb(done[2]),
        .o_write_bram_stb(wstb[2]), .o_write_bram_addr(ba2), .o_write_bram_data(bd2),
        .o_spi_cs_n(cs_n[2]), .o_spi_clk(sclk[2]), .o_spi_mosi(mosi[2]), .i_spi_miso(miso[2])
    );

    assign miso[0] = st[0].miso;
    assign miso[1] = st[1].miso;
    assign miso[2] = st[2].miso;

    // Flash memory contents as a function of byte address.
    function automatic logic [7:0] fbyte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic mon_t mon_clear(input mon_t s);
        mon_t n;
        n          = s;
        n.miso     = 1'b0;
        n.seen_tog = 1'b0;
        n.hdr      = 64'd0;
        n.edges    = 0;
        n.strobes  = 0;
        n.str_bad  = 0;
        n.dones    = 0;
        n.both     = 0;
        n.mosi_bad = 0;
        n.hp_min   = 1000000;
        n.hp_max   = 0;
        n.hp_cnt   = 0;
        return n;
    endfunction

    // One observation step: flash slave behaviour plus transaction statistics.
    function automatic mon_t mon_next(input mon_t s, input logic r, input int ab, input int fr,
                                      input logic [31:0] rq, input logic cs_n_i,
                                      input logic sclk_i, input logic mosi_i, input logic stb_i,
                                      input logic [31:0] baddr, input logic [7:0] bdata,
                                      input logic done_i);
        mon_t        n;
        int          hb, db, k;
        logic [31:0] fa;
        logic [7:0]  b;
        n  = s;
        hb = 8 + 8 * ab;
        db = hb + 8 * fr;
        if (r) begin
            n           = mon_clear(n);
            n.cs_prev   = 1'b1;
            n.sclk_prev = 1'b1;
            return n;
        end
        if (s.cs_prev && !cs_n_i) n = mon_clear(n);
        n.hp_cnt++;
        if (!cs_n_i && sclk_i != s.sclk_prev) begin
            if (n.seen_tog) begin
                if (n.hp_cnt < n.hp_min) n.hp_min = n.hp_cnt;
                if (n.hp_cnt > n.hp_max) n.hp_max = n.hp_cnt;
            end
            n.seen_tog = 1'b1;
            n.hp_cnt   = 0;
        end
        if (!cs_n_i && sclk_i && !s.sclk_prev) begin
            if (n.edges < hb) n.hdr = {n.hdr[62:0], mosi_i};
            else if (!mosi_i) n.mosi_bad++;
            n.edges++;
        end
        if (!cs_n_i && !sclk_i && s.sclk_prev && n.edges >= db) begin
            k      = n.edges - db;
            fa     = (ab == 4) ? n.hdr[31:0] : {8'h00, n.hdr[23:0]};
            b      = fbyte(fa + 32'(k / 8));
            n.miso = b[7 - (k % 8)];
        end
        if (cs_n_i && (!mosi_i || !sclk_i)) n.mosi_bad++;
        if (stb_i) begin
            if (baddr != 32'(n.strobes) || bdata != fbyte(rq + 32'(n.strobes))) n.str_bad++;
            n.strobes++;
        end
        if (done_i) n.dones++;
        if (stb_i && done_i) n.both++;
        n.cs_prev   = cs_n_i;
        n.sclk_prev = sclk_i;
        return n;
    endfunction

    always @(negedge clk) begin
        st[0] <= mon_next(st[0], rst, 3, 0, req[0], cs_n[0], sclk[0], mosi[0], wstb[0],
                          32'(ba0), bd0, done[0]);
        st[1] <= mon_next(st[1], rst, 4, 1, req[1], cs_n[1], sclk[1], mosi[1], wstb[1],
                          32'(ba1), bd1, done[1]);
        st[2] <= mon_next(st[2], rst, 3, 0, req[2], cs_n[2], sclk[2], mosi[2], wstb[2],
                          32'(ba2), bd2, done[2]);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_read(input int g, input logic [31:0] a);
        @(negedge clk);
        addr_in[g] = a;
        req[g]     = a;
        stb[g]     = 1'b1;
        @(negedge clk);
        stb[g] = 1'b0;
        check("busy_after_accept", 64'(busy[g]), 64'd1);
    endtask

    task automatic wait_edges(input int g, input int n, input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while (st[g].edges < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("edge_wait", 64'(st[g].edges >= n), 64'd1);
    endtask

    task automatic wait_done(input int g, input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while (st[g].dones == 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        repeat (4) @(negedge clk);
        check("done_seen", 64'(st[g].dones), 64'd1);
    endtask

    task automatic check_txn(input int g, input int ab, input int fr, input int bs,
                             input int div, input logic [7:0] cmd);
        logic [63:0] exp_hdr;
        exp_hdr = (ab == 4) ? {24'h0, cmd, req[g]} : {32'h0, cmd, req[g][23:0]};
        check("mosi_header", st[g].hdr, exp_hdr);
        check("rising_edges", 64'(st[g].edges), 64'(8 + 8 * ab + 8 * fr + 8 * bs));
        check("strobe_count", 64'(st[g].strobes), 64'(bs));
        check("strobe_data", 64'(st[g].str_bad), 64'd0);
        check("both_strobes", 64'(st[g].both), 64'd0);
        check("mosi_idle_dummy", 64'(st[g].mosi_bad), 64'd0);
        check("half_period_min", 64'(st[g].hp_min), 64'(div));
        check("half_period_max", 64'(st[g].hp_max), 64'(div));
        check("busy_after_done", 64'({busy[g], cs_n[g]}), 64'b01);
    endtask

    initial begin
        rst   = 1'b1;
        stb   = 3'b000;
        abort = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_in[i] = 32'd0;
            req[i]     = 32'd0;
        end
        repeat (3) @(negedge clk);
        check("reset_lines_u0", 64'({cs_n[0], sclk[0], mosi[0], busy[0], wstb[0], done[0]}),
              64'b111000);
        check("reset_bram_u0", 64'({ba0, bd0}), 64'd0);
        check("reset_lines_u1", 64'({cs_n[1], sclk[1], mosi[1], busy[1]}), 64'b1110);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Random block reads on the 3-byte, normal-read configuration.
        for (int t = 0; t < 3; t++) begin
            start_read(0, $urandom & 32'h00FF_FFFF);
            wait_done(0, 5000);
            check_txn(0, 3, 0, 16, 3, 8'h03);
        end

        // 4-byte address, fast read, divide-by-1.
        start_read(1, $urandom);
        wait_done(1, 2000);
        check_txn(1, 4, 1, 4, 1, 8'h0C);

        // Slowest divider.
        start_read(2, $urandom & 32'h00FF_FFFF);
        wait_done(2, 40000);
        check_txn(2, 3, 0, 2, 255, 8'h03);

        // A second strobe mid-transaction must be ignored.
        start_read(0, $urandom & 32'h00FF_FFFF);
        wait_edges(0, 20, 2000);
        @(negedge clk);
        addr_in[0] = req[0] ^ 32'h0055_AA55;
        stb[0]     = 1'b1;
        @(negedge clk);
        stb[0] = 1'b0;
        wait_done(0, 5000);
        check_txn(0, 3, 0, 16, 3, 8'h03);

        // Abort while receiving byte 3, then a fresh read starting at index 0.
        start_read(0, $urandom & 32'h00FF_FFFF);
        wait_edges(0, 32 + 3 * 8 + 3, 3000);
        @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("abort_lines", 64'({cs_n[0], sclk[0], mosi[0], busy[0]}), 64'b1110);
        repeat (100) @(negedge clk);
        check("abort_strobes", 64'(st[0].strobes), 64'd3);
        check("abort_no_done", 64'(st[0].dones), 64'd0);
        start_read(0, 32'h0000_0010);
        wait_done(0, 5000);
        check_txn(0, 3, 0, 16, 3, 8'h03);

        // Abort in idle does nothing; abort together with a strobe in idle accepts the read.
        @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("idle_abort", 64'({cs_n[0], busy[0]}), 64'b10);
        @(negedge clk);
        addr_in[0] = $urandom & 32'h00FF_FFFF;
        req[0]     = addr_in[0];
        stb[0]     = 1'b1;
        abort[0]   = 1'b1;
        @(negedge clk);
        stb[0]   = 1'b0;
        abort[0] = 1'b0;
        check("stb_abort_idle", 64'(busy[0]), 64'd1);
        wait_done(0, 5000);
        check_txn(0, 3, 0, 16, 3, 8'h03);

        // Asynchronous reset during the address phase.
        start_read(0, $urandom & 32'h00FF_FFFF);
        wait_edges(0, 14, 2000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_lines", 64'({cs_n[0], sclk[0], mosi[0], busy[0], wstb[0], done[0]}),
              64'b111000);
        check("async_rst_bram", 64'({ba0, bd0}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("post_rst_strobes", 64'(st[0].strobes), 64'd0);
        check("post_rst_done", 64'(st[0].dones), 64'd0);
        start_read(0, $urandom & 32'h00FF_FFFF);
        wait_done(0, 5000);
        check_txn(0, 3, 0, 16, 3, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
